// File: rtl/pe_sparse_mc_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pe_sparse_mc_if                                                  |
// | Brief    : Control, weight-load, feature and result bundle of pe_sparse_mc  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
interface pe_sparse_mc_if #(
    parameter int I_WIDTH   = 8,
    parameter int F_WIDTH   = 8,
    parameter int N         = 3,
    parameter int C         = 2,
    parameter int ACC_WIDTH = I_WIDTH + F_WIDTH + $clog2(N) + 1
);
    localparam int c_ch_w   = (C > 1) ? $clog2(C) : 1;
    localparam int c_tap_w  = (N > 1) ? $clog2(N) : 1;
    localparam int c_size_w = $clog2(N + 1);

    logic                      load_i;
    logic                      w_valid_i;
    logic [c_ch_w-1:0]         w_ch_i;
    logic [c_tap_w-1:0]        w_tap_i;
    logic [F_WIDTH-1:0]        w_data_i;
    logic                      start_i;
    logic                      stop_i;
    logic [c_size_w-1:0]       filter_size_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [I_WIDTH-1:0]        in_feature_i;
    logic [C*ACC_WIDTH-1:0]    psum_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [C*ACC_WIDTH-1:0]    out_psum_o;
    logic                      busy_o;
    logic [15:0]               skip_cnt_o;

    modport slave (
        input  load_i, w_valid_i, w_ch_i, w_tap_i, w_data_i,
        input  start_i, stop_i, filter_size_i,
        input  in_valid_i, in_feature_i, psum_i, out_ready_i,
        output in_ready_o, out_valid_o, out_psum_o, busy_o, skip_cnt_o
    );

    modport master (
        output load_i, w_valid_i, w_ch_i, w_tap_i, w_data_i,
        output start_i, stop_i, filter_size_i,
        output in_valid_i, in_feature_i, psum_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_psum_o, busy_o, skip_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pe_sparse_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pe_sparse_mc                                                     |
// | Brief    : Multi-channel sparse 1-D conv PE, one shared multiplier,         |
// |            zero-weight taps skipped, partial sums chained from above        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module pe_sparse_mc #(
    parameter int I_WIDTH   = 8,
    parameter int F_WIDTH   = 8,
    parameter int N         = 3,
    parameter int C         = 2,
    parameter int ACC_WIDTH = I_WIDTH + F_WIDTH + $clog2(N) + 1
) (
    input  wire logic     clk_i,
    input  wire logic     rst_n_i,
    pe_sparse_mc_if.slave bus
);
    localparam int c_size_w = $clog2(N + 1);
    localparam int c_prod_w = I_WIDTH + F_WIDTH;
    localparam int c_nnz_w  = $clog2(C * N + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_MAC  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;

    logic signed [F_WIDTH-1:0]    r_weight [C][N];
    logic signed [I_WIDTH-1:0]    r_win    [N];
    logic signed [ACC_WIDTH-1:0]  r_acc    [C];
    logic signed [ACC_WIDTH-1:0]  r_psum   [C];
    logic [c_size_w-1:0]          r_size;
    logic [c_size_w-1:0]          r_fill;
    logic [C*N-1:0]               r_pend;
    logic [C*ACC_WIDTH-1:0]       r_out_psum;
    logic [15:0]                  r_skip;

    logic [c_size_w-1:0]          w_size_req;
    logic [c_size_w-1:0]          w_fill_inc;
    logic                         w_accept;
    logic                         w_fill_done;
    logic                         w_stop;
    logic                         w_mac_last;
    logic [C*N-1:0]               w_nz_mask;
    logic [c_nnz_w-1:0]           w_nnz;
    logic [16:0]                  w_skip_sum;
    logic [C*N-1:0]               w_sel_oh;
    logic [C-1:0]                 w_sel_ch;
    logic                         w_found;
    logic signed [F_WIDTH-1:0]    w_sel_w;
    logic signed [I_WIDTH-1:0]    w_sel_x;
    logic signed [c_prod_w-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_next [C];

    // A requested size of zero or beyond the tap count means "use every tap".
    assign w_size_req = (bus.filter_size_i == '0 || int'(bus.filter_size_i) > N)
                        ? c_size_w'(N) : bus.filter_size_i;
    assign w_fill_inc  = (r_fill == r_size) ? r_size : r_fill + 1'b1;
    assign w_stop      = bus.stop_i && (r_state == S_FILL || r_state == S_MAC || r_state == S_OUT);
    assign w_accept    = (r_state == S_FILL) && bus.in_valid_i && !bus.stop_i;
    assign w_fill_done = w_accept && (w_fill_inc == r_size);
    assign w_mac_last  = (r_pend & ~w_sel_oh) == '0;
    assign w_skip_sum  = {1'b0, r_skip} + (17'(C) * 17'(r_size)) - 17'(w_nnz);

    always_comb begin
        w_nz_mask = '0;
        w_nnz     = '0;
        for (int c = 0; c < C; c++) begin
            for (int t = 0; t < N; t++) begin
                if (t < int'(r_size) && r_weight[c][t] != '0) begin
                    w_nz_mask[c*N + t] = 1'b1;
                    w_nnz              = w_nnz + 1'b1;
                end
            end
        end
    end

    // Lowest pending bit is the next pair in channel-major, tap-ascending order.
    always_comb begin
        w_found  = 1'b0;
        w_sel_oh = '0;
        w_sel_ch = '0;
        w_sel_w  = '0;
        w_sel_x  = '0;
        for (int c = 0; c < C; c++) begin
            for (int t = 0; t < N; t++) begin
                if (!w_found && r_pend[c*N + t]) begin
                    w_found            = 1'b1;
                    w_sel_oh[c*N + t]  = 1'b1;
                    w_sel_ch[c]        = 1'b1;
                    w_sel_w            = r_weight[c][t];
                    w_sel_x            = r_win[t];
                end
            end
        end
    end

    assign w_prod     = w_sel_x * w_sel_w;
    assign w_prod_ext = {{(ACC_WIDTH - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

    always_comb begin
        for (int c = 0; c < C; c++) begin
            w_acc_next[c] = r_acc[c];
            if (w_sel_ch[c]) begin
                w_acc_next[c] = r_acc[c] + w_prod_ext;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.load_i) begin
                    w_state_next = S_LOAD;
                end else if (bus.start_i) begin
                    w_state_next = S_FILL;
                end
            end
            S_LOAD: begin
                if (!bus.load_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FILL: begin
                if (bus.stop_i) begin
                    w_state_next = S_IDLE;
                end else if (w_fill_done) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (bus.stop_i) begin
                    w_state_next = S_IDLE;
                end else if (w_mac_last) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.stop_i) begin
                    w_state_next = S_IDLE;
                end else if (bus.out_ready_i) begin
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < C; c++) begin
                for (int t = 0; t < N; t++) begin
                    r_weight[c][t] <= '0;
                end
                r_acc[c]  <= '0;
                r_psum[c] <= '0;
            end
            for (int t = 0; t < N; t++) begin
                r_win[t] <= '0;
            end
            r_size     <= '0;
            r_fill     <= '0;
            r_pend     <= '0;
            r_out_psum <= '0;
            r_skip     <= '0;
        end else begin
            if (r_state == S_LOAD && bus.w_valid_i) begin
                for (int c = 0; c < C; c++) begin
                    for (int t = 0; t < N; t++) begin
                        if (int'(bus.w_ch_i) == c && int'(bus.w_tap_i) == t) begin
                            r_weight[c][t] <= bus.w_data_i;
                        end
                    end
                end
            end
            if (r_state == S_IDLE && !bus.load_i && bus.start_i) begin
                r_size <= w_size_req;
                r_fill <= '0;
            end
            if (w_stop) begin
                r_fill <= '0;
                for (int t = 0; t < N; t++) begin
                    r_win[t] <= '0;
                end
            end
            if (w_accept) begin
                r_win[0] <= bus.in_feature_i;
                for (int t = 1; t < N; t++) begin
                    r_win[t] <= r_win[t-1];
                end
                r_fill <= w_fill_inc;
                if (w_fill_done) begin
                    for (int c = 0; c < C; c++) begin
                        r_psum[c] <= bus.psum_i[c*ACC_WIDTH +: ACC_WIDTH];
                        r_acc[c]  <= '0;
                    end
                    r_pend <= w_nz_mask;
                    r_skip <= w_skip_sum[16] ? 16'hFFFF : w_skip_sum[15:0];
                end
            end
            if (r_state == S_MAC && !bus.stop_i) begin
                r_pend <= r_pend & ~w_sel_oh;
                for (int c = 0; c < C; c++) begin
                    r_acc[c] <= w_acc_next[c];
                end
                // Result folds in the final product directly, so OUT follows the last pair.
                if (w_mac_last) begin
                    for (int c = 0; c < C; c++) begin
                        r_out_psum[c*ACC_WIDTH +: ACC_WIDTH] <= r_psum[c] + w_acc_next[c];
                    end
                end
            end
        end
    end

    assign bus.in_ready_o  = (r_state == S_FILL);
    assign bus.out_valid_o = (r_state == S_OUT);
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.out_psum_o  = r_out_psum;
    assign bus.skip_cnt_o  = r_skip;
endmodule
`default_nettype wire

// File: tb/tb_pe_sparse_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_pe_sparse_mc                                                  |
// | Brief    : Self-checking bench for pe_sparse_mc against a window-sum model  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_pe_sparse_mc;
    localparam int I_WIDTH   = 8;
    localparam int F_WIDTH   = 8;
    localparam int N         = 3;
    localparam int C         = 2;
    localparam int ACC_WIDTH = I_WIDTH + F_WIDTH + $clog2(N) + 1;
    localparam int CH_W      = (C > 1) ? $clog2(C) : 1;
    localparam int TAP_W     = (N > 1) ? $clog2(N) : 1;
    localparam int SIZE_W    = $clog2(N + 1);
    localparam int BUDGET    = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_w   [C][N];
    int   m_win [N];
    int   m_size;
    int   m_fill;
    int   m_skip;
    int   ld_w  [C][N];

    pe_sparse_mc_if #(.I_WIDTH(I_WIDTH), .F_WIDTH(F_WIDTH), .N(N), .C(C),
                      .ACC_WIDTH(ACC_WIDTH)) bus ();

    pe_sparse_mc #(.I_WIDTH(I_WIDTH), .F_WIDTH(F_WIDTH), .N(N), .C(C),
                   .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [C*ACC_WIDTH-1:0] pack2(input int a, input int b);
        logic [C*ACC_WIDTH-1:0] v;
        v = '0;
        v[0 +: ACC_WIDTH]         = ACC_WIDTH'(a);
        v[ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(b);
        return v;
    endfunction

    function automatic void model_clear_window();
        m_fill = 0;
        for (int t = 0; t < N; t++) m_win[t] = 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < C; c++)
            for (int t = 0; t < N; t++) m_w[c][t] = 0;
        model_clear_window();
        m_skip = 0;
        m_size = N;
    endfunction

    function automatic int model_nnz();
        int n = 0;
        for (int c = 0; c < C; c++)
            for (int t = 0; t < m_size; t++)
                if (m_w[c][t] != 0) n++;
        return n;
    endfunction

    // Expected result: upper partial sum plus the dot product of active weights and window.
    function automatic logic signed [ACC_WIDTH-1:0] model_out(input int c,
                                                              input logic signed [ACC_WIDTH-1:0] p);
        int s = 0;
        for (int t = 0; t < m_size; t++) s += m_w[c][t] * m_win[t];
        return p + ACC_WIDTH'(s);
    endfunction

    function automatic bit model_accept(input int f);
        int sk;
        for (int t = N - 1; t > 0; t--) m_win[t] = m_win[t-1];
        m_win[0] = f;
        if (m_fill < m_size) m_fill++;
        if (m_fill == m_size) begin
            sk = m_skip + C * m_size - model_nnz();
            m_skip = (sk > 65535) ? 65535 : sk;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_idle_inputs();
        bus.load_i        = 1'b0;
        bus.w_valid_i     = 1'b0;
        bus.w_ch_i        = '0;
        bus.w_tap_i       = '0;
        bus.w_data_i      = '0;
        bus.start_i       = 1'b0;
        bus.stop_i        = 1'b0;
        bus.filter_size_i = '0;
        bus.in_valid_i    = 1'b0;
        bus.in_feature_i  = '0;
        bus.psum_i        = '0;
        bus.out_ready_i   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic load_weights();
        bus.load_i = 1'b1;
        tick();
        n_checks++;
        if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL load_state: busy=%b in_ready=%b, required busy=1 in_ready=0",
                     bus.busy_o, bus.in_ready_o);
        end
        for (int c = 0; c < C; c++) begin
            for (int t = 0; t < N; t++) begin
                bus.w_valid_i = 1'b1;
                bus.w_ch_i    = CH_W'(c);
                bus.w_tap_i   = TAP_W'(t);
                bus.w_data_i  = F_WIDTH'(ld_w[c][t]);
                tick();
                m_w[c][t] = ld_w[c][t];
            end
        end
        // Tap index N is out of range and must leave every weight untouched.
        bus.w_ch_i   = '0;
        bus.w_tap_i  = TAP_W'(N);
        bus.w_data_i = 8'h55;
        tick();
        bus.w_valid_i = 1'b0;
        bus.load_i    = 1'b0;
        tick();
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL load_exit: busy=%b, required 0", bus.busy_o);
        end
    endtask

    task automatic start_stream(input int size);
        bus.filter_size_i = SIZE_W'(size);
        bus.start_i       = 1'b1;
        tick();
        bus.start_i = 1'b0;
        m_size = (size == 0 || size > N) ? N : size;
        m_fill = 0;
        n_checks++;
        if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL start_fill: in_ready=%b busy=%b, required 1 1", bus.in_ready_o, bus.busy_o);
        end
    endtask

    task automatic stop_stream();
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        model_clear_window();
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_idle: busy=%b out_valid=%b in_ready=%b, required 0 0 0",
                     bus.busy_o, bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic send_raw(input int f, input logic [C*ACC_WIDTH-1:0] pv, output bit fired);
        bus.in_valid_i   = 1'b1;
        bus.in_feature_i = I_WIDTH'(f);
        bus.psum_i       = pv;
        tick();
        bus.in_valid_i = 1'b0;
        fired = model_accept(f);
    endtask

    task automatic do_feature(input int f, input logic [C*ACC_WIDTH-1:0] pv, input int stall,
                              output bit fired, output logic [C*ACC_WIDTH-1:0] got,
                              output int cyc);
        logic signed [ACC_WIDTH-1:0] exp_c;
        int exp_cyc;
        cyc = 0;
        got = '0;
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL feat_ready: in_ready=%b, required 1", bus.in_ready_o);
        end
        send_raw(f, pv, fired);
        if (!fired) begin
            n_checks++;
            if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
                n_errors++;
                $display("FAIL fill_hold: out_valid=%b in_ready=%b, required 0 1",
                         bus.out_valid_o, bus.in_ready_o);
            end
            return;
        end
        exp_cyc = (model_nnz() == 0) ? 1 : model_nnz();
        while (bus.out_valid_o !== 1'b1 && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != exp_cyc) begin
            n_errors++;
            $display("FAIL mac_cycles: got %0d, required %0d", cyc, exp_cyc);
        end
        if (cyc >= BUDGET) return;
        got = bus.out_psum_o;
        for (int c = 0; c < C; c++) begin
            exp_c = model_out(c, pv[c*ACC_WIDTH +: ACC_WIDTH]);
            n_checks++;
            if (got[c*ACC_WIDTH +: ACC_WIDTH] !== exp_c) begin
                n_errors++;
                $display("FAIL out_psum ch%0d: got %0d, required %0d", c,
                         $signed(got[c*ACC_WIDTH +: ACC_WIDTH]), exp_c);
            end
        end
        n_checks++;
        if (bus.skip_cnt_o !== 16'(m_skip) || bus.in_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL skip_cnt: got %0d in_ready=%b, required %0d in_ready=0",
                     bus.skip_cnt_o, bus.in_ready_o, m_skip);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            n_checks++;
            if (bus.out_psum_o !== got || bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL out_hold: psum=%h valid=%b in_ready=%b, required psum=%h valid=1 in_ready=0",
                         bus.out_psum_o, bus.out_valid_o, bus.in_ready_o, got);
            end
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL out_to_fill: out_valid=%b in_ready=%b, required 0 1",
                     bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic set_ld(input int a0, a1, a2, b0, b1, b2);
        ld_w[0][0] = a0; ld_w[0][1] = a1; ld_w[0][2] = a2;
        ld_w[1][0] = b0; ld_w[1][1] = b1; ld_w[1][2] = b2;
    endtask

    task automatic test_reset();
        drive_idle_inputs();
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.skip_cnt_o !== 16'd0 || bus.out_psum_o !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b skip=%0d psum=%h, required all zero",
                     bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.skip_cnt_o, bus.out_psum_o);
        end
        do_reset();
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b in_ready=%b, required 0 0", bus.busy_o, bus.in_ready_o);
        end
    endtask

    task automatic test_basic_stride();
        bit fired;
        logic [C*ACC_WIDTH-1:0] got;
        int cyc;
        set_ld(1, 2, 3, -1, -1, -1);
        load_weights();
        start_stream(3);
        do_feature(1, pack2(0, 0), 0, fired, got, cyc);
        do_feature(2, pack2(0, 0), 0, fired, got, cyc);
        do_feature(3, pack2(0, 0), 5, fired, got, cyc);
        n_checks++;
        if (!fired || got !== pack2(10, -6) || cyc != 6 || bus.skip_cnt_o !== 16'd0) begin
            n_errors++;
            $display("FAIL basic_literal: got %h cyc=%0d skip=%0d, required %h cyc=6 skip=0",
                     got, cyc, bus.skip_cnt_o, pack2(10, -6));
        end
        do_feature(10, pack2(0, 0), 0, fired, got, cyc);
        n_checks++;
        if (!fired || got !== pack2(22, -15)) begin
            n_errors++;
            $display("FAIL stride_literal: got %h fired=%b, required %h", got, fired, pack2(22, -15));
        end
        stop_stream();
    endtask

    task automatic test_size2();
        bit fired;
        logic [C*ACC_WIDTH-1:0] got;
        int cyc;
        start_stream(2);
        do_feature(5, pack2(0, 0), 0, fired, got, cyc);
        do_feature(6, pack2(0, 0), 1, fired, got, cyc);
        n_checks++;
        if (!fired || got !== pack2(16, -11) || cyc != 4) begin
            n_errors++;
            $display("FAIL size2_literal: got %h cyc=%0d, required %h cyc=4", got, cyc, pack2(16, -11));
        end
        stop_stream();
    endtask

    task automatic test_stop_mid_mac();
        bit fired;
        logic [C*ACC_WIDTH-1:0] got;
        int cyc;
        start_stream(3);
        send_raw(7, '0, fired);
        send_raw(8, '0, fired);
        send_raw(9, '0, fired);
        stop_stream();
        start_stream(3);
        do_feature(1, pack2(0, 0), 0, fired, got, cyc);
        do_feature(2, pack2(0, 0), 0, fired, got, cyc);
        do_feature(3, pack2(0, 0), 0, fired, got, cyc);
        n_checks++;
        if (!fired || got !== pack2(10, -6)) begin
            n_errors++;
            $display("FAIL stop_refill: got %h fired=%b, required %h", got, fired, pack2(10, -6));
        end
        stop_stream();
    endtask

    task automatic test_sparse();
        bit fired;
        logic [C*ACC_WIDTH-1:0] got;
        int cyc;
        int skip0;
        set_ld(0, 0, 5, 0, 0, 0);
        load_weights();
        skip0 = int'(bus.skip_cnt_o);
        start_stream(3);
        do_feature(4, pack2(0, 0), 0, fired, got, cyc);
        do_feature(7, pack2(0, 0), 0, fired, got, cyc);
        do_feature(9, pack2(100, -3), 0, fired, got, cyc);
        n_checks++;
        if (!fired || got !== pack2(120, -3) || cyc != 1 || int'(bus.skip_cnt_o) != skip0 + 5) begin
            n_errors++;
            $display("FAIL sparse_literal: got %h cyc=%0d skip=%0d, required %h cyc=1 skip=%0d",
                     got, cyc, bus.skip_cnt_o, pack2(120, -3), skip0 + 5);
        end
        stop_stream();
    endtask

    task automatic test_reset_mid_mac();
        bit fired;
        logic [C*ACC_WIDTH-1:0] got;
        int cyc;
        set_ld(1, 2, 3, -1, -1, -1);
        load_weights();
        start_stream(3);
        send_raw(1, '0, fired);
        send_raw(2, '0, fired);
        send_raw(3, '0, fired);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b0 ||
            bus.skip_cnt_o !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid_mac: vld=%b busy=%b rdy=%b skip=%0d, required all zero",
                     bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.skip_cnt_o);
        end
        do_reset();
        start_stream(3);
        do_feature(1, pack2(0, 0), 0, fired, got, cyc);
        do_feature(2, pack2(0, 0), 0, fired, got, cyc);
        do_feature(3, pack2(7, -7), 0, fired, got, cyc);
        n_checks++;
        if (!fired || got !== pack2(7, -7) || cyc != 1 || bus.skip_cnt_o !== 16'd6) begin
            n_errors++;
            $display("FAIL zero_weights: got %h cyc=%0d skip=%0d, required %h cyc=1 skip=6",
                     got, cyc, bus.skip_cnt_o, pack2(7, -7));
        end
        stop_stream();
    endtask

    task automatic test_random();
        bit fired;
        logic [C*ACC_WIDTH-1:0] got;
        logic [C*ACC_WIDTH-1:0] pv;
        int cyc;
        int nres;
        int guard;
        for (int it = 0; it < 20; it++) begin
            for (int c = 0; c < C; c++)
                for (int t = 0; t < N; t++)
                    ld_w[c][t] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            load_weights();
            start_stream(int'($urandom_range(0, N)));
            nres  = int'($urandom_range(1, 3));
            guard = 0;
            while (nres > 0 && guard < 20) begin
                for (int c = 0; c < C; c++) pv[c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom);
                do_feature(int'($urandom_range(0, 255)) - 128, pv, int'($urandom_range(0, 3)),
                           fired, got, cyc);
                if (fired) nres--;
                guard++;
            end
            stop_stream();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_stride();
        test_size2();
        test_stop_mid_mac();
        test_sparse();
        test_random();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
